// File: rtl/aes_round_tf_p.sv
`default_nettype none
// ============================================================================
// aes_round_tf_p : one AES-128 encryption round, SubBytes over SBOX_LANES lanes
// Revision: 1.0
// ============================================================================
module aes_round_tf_p #(
  parameter int SBOX_LANES = 4,
  parameter int REG_OUT    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         final_i,
  input  logic [127:0] s_i,
  input  logic [127:0] rk_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] s_sr_o,
  output logic [127:0] s_o
);

  localparam int         c_GROUPS = 16 / SBOX_LANES;
  localparam logic [3:0] c_LAST   = 4'(c_GROUPS - 1);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
      SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
    $error("aes_round_tf_p: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic [127:0] st_q;
  logic [127:0] key_q;
  logic [127:0] so_q;
  logic [127:0] sr_q;
  logic         fin_q;
  logic         busy_q;
  logic         done_q;

  logic [7:0]   st_b  [16];
  logic [7:0]   sr_b  [16];
  logic [7:0]   mc_b  [16];
  logic [7:0]   sub_b [SBOX_LANES];
  logic [127:0] st_d;
  logic [127:0] sr_d;
  logic [127:0] res_d;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return c_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
    logic [3:0] idx;
    assign idx      = 4'(32'(cnt_q) * SBOX_LANES + j);
    assign sub_b[j] = sbox(st_b[idx]);
  end

  // Only the bytes of the current group take a lane result; the rest hold.
  for (genvar k = 0; k < 16; k++) begin : g_bytes
    assign st_b[k] = st_q[127-8*k -: 8];
    assign st_d[127-8*k -: 8] = (cnt_q == 4'(k / SBOX_LANES)) ? sub_b[k % SBOX_LANES]
                                                               : st_b[k];
  end

  // Byte 4c+r is column c, row r; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_b[4*c+r] = st_b[4*((c+r)%4)+r];
      assign mc_b[4*c+r] = xtime(sr_b[4*c+r]) ^ xtime(sr_b[4*c+(r+1)%4]) ^
                           sr_b[4*c+(r+1)%4] ^ sr_b[4*c+(r+2)%4] ^ sr_b[4*c+(r+3)%4];
      assign sr_d[127-8*(4*c+r) -: 8]  = sr_b[4*c+r];
      assign res_d[127-8*(4*c+r) -: 8] = (fin_q ? sr_b[4*c+r] : mc_b[4*c+r]) ^
                                         key_q[127-8*(4*c+r) -: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      key_q   <= '0;
      so_q    <= '0;
      sr_q    <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            st_q    <= s_i;
            key_q   <= rk_i;
            fin_q   <= final_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SUB;
          end
        end
        ST_SUB: begin
          st_q <= st_d;
          if (cnt_q == c_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_MIX;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_MIX: begin
          sr_q    <= sr_d;
          so_q    <= res_d;
          st_q    <= res_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign s_sr_o = sr_q;

  if (REG_OUT != 0) begin : g_reg_out
    assign s_o = so_q;
  end else begin : g_comb_out
    assign s_o = st_q;
  end

endmodule
`default_nettype wire
